// File: rtl/alu8_pkg.sv
// alu8_pkg: opcodes, flag/entry types and flag derivation shared by the ALU result path
package alu8_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;
  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
  } alu8_flags_t;
  typedef struct packed {
    logic [8:0]  result;
    logic [2:0]  sel;
    alu8_flags_t flags;
  } alu8_entry_t;
  // Bit 8 is a carry/borrow only for ADD/SUB; inverting ops set it as a side effect
  function automatic alu8_flags_t alu8_flags(input logic [8:0] result, input logic [2:0] sel);
    alu8_flags_t f;
    f.zero  = result[7:0] == 8'd0;
    f.carry = result[8] && (sel == OP_ADD || sel == OP_SUB);
    f.neg   = result[7];
    return f;
  endfunction
endpackage

// File: rtl/alu8_sync_fifo.sv
// alu8_sync_fifo: generic synchronous FIFO with occupancy count and full-drop strobe
module alu8_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q, count_d;
  logic full, do_push, do_pop;
  always_comb begin
    full    = count_q == (AW+1)'(DEPTH);
    do_pop  = pop_i && count_q != '0;
    do_push = push_i && (!full || do_pop);
    drop_o  = push_i && !do_push;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end
  assign dout_o  = mem_q[rd_q];
  assign valid_o = count_q != '0;
  assign count_o = count_q;
endmodule

// File: rtl/alu8_result_fifo.sv
// alu8_result_fifo: aligns issue tags with the registered ALU result, flags it and buffers it with credit flow control
module alu8_result_fifo
  import alu8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2:0]             in_sel,
  input  logic [8:0]             alu_result,
  output logic                   issue_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8:0]             out_result,
  output logic [2:0]             out_sel,
  output logic                   out_zero,
  output logic                   out_carry,
  output logic                   out_neg,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic stg_valid_q, overflow_q, overflow_d, drop;
  logic [2:0] stg_sel_q;
  alu8_entry_t push_entry, head;
  always_comb begin
    push_entry.result = alu_result;
    push_entry.sel    = stg_sel_q;
    push_entry.flags  = alu8_flags(alu_result, stg_sel_q);
    overflow_d        = overflow_q || drop;
    // The in-flight op in the align stage already owns a slot
    issue_ready       = ({1'b0, count} + (CW+1)'(stg_valid_q)) < (CW+1)'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_q <= 1'b0;
      stg_sel_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      stg_valid_q <= in_valid;
      stg_sel_q   <= in_sel;
      overflow_q  <= overflow_d;
    end
  end
  alu8_sync_fifo #(.WIDTH($bits(alu8_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (stg_valid_q),
    .din_i  (push_entry),
    .pop_i  (out_ready),
    .dout_o (head),
    .valid_o(out_valid),
    .count_o(count),
    .drop_o (drop)
  );
  assign out_result = head.result;
  assign out_sel    = head.sel;
  assign out_zero   = head.flags.zero;
  assign out_carry  = head.flags.carry;
  assign out_neg    = head.flags.neg;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_alu8_result_fifo.sv
// tb_alu8_result_fifo: randomized and directed checks against a queue-based reference model
module tb_alu8_result_fifo;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] in_sel = '0;
  logic [8:0] alu_result = '0;
  logic [7:0] a = '0, b = '0;
  logic issue_ready, out_valid, out_zero, out_carry, out_neg, overflow;
  logic [8:0] out_result;
  logic [2:0] out_sel;
  logic [$clog2(DEPTH):0] count;
  int n_cmp = 0, n_err = 0;
  logic [11:0] q[$];
  logic [11:0] pend_e = '0;
  logic pend = 1'b0, ovf = 1'b0;
  alu8_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .alu_result(alu_result),
    .issue_ready(issue_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sel(out_sel), .out_zero(out_zero), .out_carry(out_carry),
    .out_neg(out_neg), .count(count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] alu(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0: return {1'b0, x & y};
      3'd1: return ~{1'b0, x & y};
      3'd2: return {1'b0, x | y};
      3'd3: return ~{1'b0, x | y};
      3'd4: return {1'b0, x ^ y};
      3'd5: return ~{1'b0, x ^ y};
      3'd6: return {1'b0, x} + {1'b0, y};
      default: return {1'b0, x} - {1'b0, y};
    endcase
  endfunction
  function automatic logic model_ready();
    return (q.size() + int'(pend)) < DEPTH;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [8:0] r;
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("count", count, q.size());
    chk("overflow", overflow, ovf);
    chk("issue_ready", issue_ready, model_ready());
    if (q.size() > 0) begin
      r = q[0][11:3];
      chk("out_result", out_result, r);
      chk("out_sel", out_sel, q[0][2:0]);
      chk("out_zero", out_zero, r[7:0] == 8'd0);
      chk("out_carry", out_carry, r[8] && q[0][2:0] >= 3'd6);
      chk("out_neg", out_neg, r[7]);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      pend = 1'b0;
      ovf  = 1'b0;
    end else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (pend) begin
        if (q.size() < DEPTH) q.push_back(pend_e);
        else ovf = 1'b1;
      end
      pend = in_valid;
    end
    pend_e = {alu(in_sel, a, b), in_sel};
    #1 alu_result = alu(in_sel, a, b);
  endtask
  task automatic issue(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; in_sel = s; a = x; b = y;
    tick();
    in_valid = 1'b0;
    tick();
  endtask
  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (DEPTH + 2) tick();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_flags", {out_zero, out_carry, out_neg}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    issue(3'd6, 8'd200, 8'd100);
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 9'h12C);
    chk("add_flags", {out_zero, out_carry, out_neg}, 3'b010);
    chk("add_sel", out_sel, 6);
    tick();
    issue(3'd7, 8'd5, 8'd10);
    chk("sub_result", out_result, 9'h1FB);
    chk("sub_flags", {out_zero, out_carry, out_neg}, 3'b011);
    tick();
    issue(3'd1, 8'hFF, 8'hFF);
    chk("nand_result", out_result, 9'h100);
    chk("nand_flags", {out_zero, out_carry, out_neg}, 3'b100);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = model_ready();
      in_sel = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      chk("credit_ready", issue_ready, i < 4);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("credit_count", count, 4);
    chk("credit_no_ovf", overflow, 0);
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = model_ready();
      in_sel = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("viol_overflow", overflow, 1);
    chk("viol_count", count, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("viol_rst_clear", overflow, 0);
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_sel = 3'd6; a = 8'd1; b = 8'd2;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", issue_ready, 1);
    chk("midrst_count", count, 0);
    repeat (3) tick();
    for (int i = 0; i < 400; i++) begin
      in_valid  = model_ready() && $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_sel = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      tick();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
